// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, ID operand forwarding and branch flush
// control for the 5-stage RV32I pipeline.
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       hazard_optype_ID,
  input  logic [REG_W-1:0] rd_ID,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic             RegWrite_ID,
  input  logic             Branch_ID,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_EXA = 2'b01;
  localparam logic [1:0] FW_MEA = 2'b10;
  localparam logic [1:0] FW_MEL = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs2;
    logic             wr;
  } ex_rec_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [REG_W-1:0] rd;
    logic             wr;
  } mem_rec_t;

  ex_rec_t  ex_q;
  mem_rec_t mem_q;

  logic ex_ld;
  logic hit1_ld;
  logic hit2_ld;
  logic stall;

  function automatic logic [1:0] fwd_sel(
    input logic             used,
    input logic [REG_W-1:0] rs,
    input ex_rec_t          ex,
    input mem_rec_t         mem
  );
    logic ex_hit;
    logic mem_hit;
    ex_hit  = ex.wr && (ex.rd != '0) && (ex.rd == rs);
    mem_hit = mem.wr && (mem.rd != '0) && (mem.rd == rs);
    fwd_sel = FW_RF;
    // a matching EX load is never forwarded; it stalls or waits in MEM
    if (!used)
      fwd_sel = FW_RF;
    else if (ex_hit && ex.op == OP_ALU)
      fwd_sel = FW_EXA;
    else if (ex_hit && ex.op == OP_LOAD)
      fwd_sel = FW_RF;
    else if (mem_hit && mem.op == OP_ALU)
      fwd_sel = FW_MEA;
    else if (mem_hit && mem.op == OP_LOAD)
      fwd_sel = FW_MEL;
  endfunction

  always_comb begin
    ex_ld   = (ex_q.op == OP_LOAD) && ex_q.wr
              && (ex_q.rd != '0);
    hit1_ld = rs1use_ID && (rs1_ID == ex_q.rd);
    hit2_ld = rs2use_ID && (rs2_ID == ex_q.rd)
              && (hazard_optype_ID != OP_STORE);
    stall   = ex_ld && (hit1_ld || hit2_ld);
  end

  always_comb begin
    forward_ctrl_A  = fwd_sel(rs1use_ID, rs1_ID, ex_q, mem_q);
    forward_ctrl_B  = fwd_sel(rs2use_ID, rs2_ID, ex_q, mem_q);
    forward_ctrl_ls = (ex_q.op == OP_STORE)
                      && (mem_q.op == OP_LOAD)
                      && mem_q.wr
                      && (mem_q.rd != '0)
                      && (mem_q.rd == ex_q.rs2);
    PC_EN_IF        = ~stall;
    reg_FD_EN       = ~stall;
    reg_DE_flush    = stall;
    reg_FD_flush    = Branch_ID & ~stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      mem_q.op <= ex_q.op;
      mem_q.rd <= ex_q.rd;
      mem_q.wr <= ex_q.wr;
      if (stall) begin
        ex_q.op  <= OP_NONE;
        ex_q.rd  <= '0;
        ex_q.rs2 <= '0;
        ex_q.wr  <= 1'b0;
      end else begin
        ex_q.op  <= hazard_optype_ID;
        ex_q.rd  <= rd_ID;
        ex_q.rs2 <= rs2_ID;
        ex_q.wr  <= RegWrite_ID;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed instruction sequences in ID, expected
// hazard outputs queued per cycle and checked by a separate monitor.
module tb_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic [1:0] hazard_optype_ID;
  logic [4:0] rd_ID;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       rs1use_ID;
  logic       rs2use_ID;
  logic       RegWrite_ID;
  logic       Branch_ID;
  logic [1:0] forward_ctrl_A;
  logic [1:0] forward_ctrl_B;
  logic       forward_ctrl_ls;
  logic       PC_EN_IF;
  logic       reg_FD_EN;
  logic       reg_FD_flush;
  logic       reg_DE_flush;

  hazard_unit #(.REG_W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hazard_optype_ID (hazard_optype_ID),
    .rd_ID            (rd_ID),
    .rs1_ID           (rs1_ID),
    .rs2_ID           (rs2_ID),
    .rs1use_ID        (rs1use_ID),
    .rs2use_ID        (rs2use_ID),
    .RegWrite_ID      (RegWrite_ID),
    .Branch_ID        (Branch_ID),
    .forward_ctrl_A   (forward_ctrl_A),
    .forward_ctrl_B   (forward_ctrl_B),
    .forward_ctrl_ls  (forward_ctrl_ls),
    .PC_EN_IF         (PC_EN_IF),
    .reg_FD_EN        (reg_FD_EN),
    .reg_FD_flush     (reg_FD_flush),
    .reg_DE_flush     (reg_DE_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fa, fb, ls, pc_en, fd_en, fd_flush, de_flush}
  typedef struct {
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [8:0] mk(
    input logic [1:0] fa,
    input logic [1:0] fb,
    input logic       ls,
    input logic       st,
    input logic       br
  );
    return {fa, fb, ls, ~st, ~st, br & ~st, st};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls,
             PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got A=%b B=%b ls=%b pc=%b fd=%b fdfl=%b defl=%b want %b_%b_%b_%b%b%b%b",
                 e.name, act[8:7], act[6:5], act[4], act[3], act[2],
                 act[1], act[0], e.v[8:7], e.v[6:5], e.v[4],
                 e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic drive(
    input string      name,
    input logic [1:0] op,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       u1,
    input logic       u2,
    input logic       wr,
    input logic       br,
    input logic [8:0] ev,
    input logic       rst_pulse
  );
    exp_t e;
    @(posedge clk);
    #1;
    hazard_optype_ID = op;
    rd_ID            = rd;
    rs1_ID           = rs1;
    rs2_ID           = rs2;
    rs1use_ID        = u1;
    rs2use_ID        = u2;
    RegWrite_ID      = wr;
    Branch_ID        = br;
    e.v    = ev;
    e.name = name;
    exp_q.push_back(e);
    if (rst_pulse) begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    hazard_optype_ID = 2'b00;
    rd_ID            = '0;
    rs1_ID           = '0;
    rs2_ID           = '0;
    rs1use_ID        = 1'b0;
    rs2use_ID        = 1'b0;
    RegWrite_ID      = 1'b0;
    Branch_ID        = 1'b0;

    drive("reset", 2'b00, 0, 0, 0, 0, 0, 0, 1,
          mk(2'b00, 2'b00, 0, 0, 1), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    drive("addi_x1", 2'b01, 1, 0, 5, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("add_ex_fwd", 2'b01, 2, 1, 3, 1, 1, 1, 0,
          mk(2'b01, 2'b00, 0, 0, 0), 0);
    drive("sub_mem_fwd", 2'b01, 4, 1, 1, 1, 1, 1, 0,
          mk(2'b10, 2'b10, 0, 0, 0), 0);
    drive("lw_x5_a", 2'b10, 5, 6, 0, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("ldu_stall", 2'b01, 7, 5, 0, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 1, 0), 0);
    drive("ldu_resume", 2'b01, 7, 5, 0, 1, 1, 1, 0,
          mk(2'b11, 2'b00, 0, 0, 0), 0);
    drive("lw_x5_b", 2'b10, 5, 6, 0, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("sw_rs2_nostall", 2'b11, 4, 8, 5, 1, 1, 0, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("ls_forward", 2'b00, 0, 0, 0, 0, 0, 0, 0,
          mk(2'b00, 2'b00, 1, 0, 0), 0);
    drive("lw_x5_c", 2'b10, 5, 6, 0, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("sw_rs1_stall", 2'b11, 0, 5, 5, 1, 1, 0, 0,
          mk(2'b00, 2'b00, 0, 1, 0), 0);
    drive("sw_rs1_resume", 2'b11, 0, 5, 5, 1, 1, 0, 0,
          mk(2'b11, 2'b11, 0, 0, 0), 0);
    drive("addi_x0", 2'b01, 0, 0, 1, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("x0_nomatch", 2'b01, 2, 0, 0, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("beq_b_fwd", 2'b00, 3, 1, 2, 1, 1, 0, 0,
          mk(2'b00, 2'b01, 0, 0, 0), 0);
    drive("nowr_nomatch", 2'b01, 4, 3, 3, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("lw_x5_d", 2'b10, 5, 6, 0, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("br_stall", 2'b00, 0, 5, 0, 1, 1, 0, 1,
          mk(2'b00, 2'b00, 0, 1, 1), 0);
    drive("br_flush", 2'b00, 0, 5, 0, 1, 1, 0, 1,
          mk(2'b11, 2'b00, 0, 0, 1), 0);
    drive("nop_after_br", 2'b00, 0, 0, 0, 0, 0, 0, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("lw_x5_e", 2'b10, 5, 6, 0, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("b2b_stall", 2'b01, 7, 5, 0, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 1, 0), 0);
    drive("b2b_mem_ld", 2'b01, 7, 5, 0, 1, 1, 1, 0,
          mk(2'b11, 2'b00, 0, 0, 0), 0);
    drive("b2b_regfile", 2'b01, 8, 5, 0, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("addi_x1_b", 2'b01, 1, 0, 5, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("add_ex_fwd_b", 2'b01, 2, 1, 3, 1, 1, 1, 0,
          mk(2'b01, 2'b00, 0, 0, 0), 0);
    drive("async_rst_fwd", 2'b01, 2, 1, 3, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 1);
    drive("lw_x5_f", 2'b10, 5, 6, 0, 1, 0, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);
    drive("async_rst_stall", 2'b01, 7, 5, 0, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 1);
    drive("post_rst_empty", 2'b01, 7, 5, 0, 1, 1, 1, 0,
          mk(2'b00, 2'b00, 0, 0, 0), 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard resolver for the 5-stage RV32I core. It consumes the per-instruction hazard descriptors produced by the decoder in ID (`hazard_optype`, `rs1use`, `rs2use`, `RegWrite`) and keeps shadow EX and MEM records of in-flight producers. From those it drives the ID-stage operand forwarding selects, the EX-stage store-data forward, load-use stalls, and branch flushes. Branches and jumps resolve in ID.

## Interface
Parameters:
- `REG_W`, 5, register index width

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `hazard_optype_ID`  in  2  00 none, 01 alu, 10 load, 11 store
- `rd_ID`  in  REG_W  destination index of ID instruction
- `rs1_ID`, `rs2_ID`  in  REG_W  source indices of ID instruction
- `rs1use_ID`, `rs2use_ID`  in  1  source actually read
- `RegWrite_ID`  in  1  ID instruction writes rd
- `Branch_ID`  in  1  taken branch/jump resolved in ID
- `forward_ctrl_A`, `forward_ctrl_B`  out  2  ID operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- `forward_ctrl_ls`  out  1  EX store data taken from MEM load data
- `PC_EN_IF`  out  1  PC register enable
- `reg_FD_EN`  out  1  IF/ID register enable
- `reg_FD_flush`  out  1  IF/ID register clears to NOP
- `reg_DE_flush`  out  1  ID/EX register loads a bubble

## Operation
- Internal records: EX = {optype, rd, rs2, wr}, MEM = {optype, rd, wr}.
- A record is a producer only if `wr`=1 and rd≠0. x0 never matches.
- `stall` (internal, combinational) is 1 when the EX record is a load producer and either:
  - `rs1use_ID` is set and rs1_ID == EX.rd, or
  - `rs2use_ID` is set, rs2_ID == EX.rd, and the ID optype is not store.
- Exception (no stall): ID is a store whose only hit is rs2 on the EX load. The store's rs1 must not also hit the EX load.
- Forward select for operand A is computed as follows. Operand B is identical, using rs2/`rs2use_ID`. A source that is not used gives 00.
  1. EX alu producer match → 01.
  2. Otherwise, MEM alu producer match → 10.
  3. Otherwise, MEM load producer match → 11.
  4. Otherwise 00.
- EX has priority over MEM: the newest value wins.
- An EX load match is never forwarded. It stalls instead, except in the store-rs2 case above, where the select stays 00 for B.
- `forward_ctrl_ls` = (EX.optype==11) & (MEM.optype==10) & MEM.wr & MEM.rd≠0 & (MEM.rd==EX.rs2).
- Control outputs:
  - `PC_EN_IF` = `reg_FD_EN` = ~stall.
  - `reg_DE_flush` = stall.
  - `reg_FD_flush` = `Branch_ID` & ~stall.
- Stall takes priority over branch: a branch whose operands are unresolved is ignored that cycle and re-evaluated next cycle.

## Timing
- Record update on posedge `clk`:
  - MEM ← EX.
  - EX ← {optype_ID, rd_ID, rs2_ID, RegWrite_ID} if ~stall, otherwise EX ← bubble (optype 00, wr 0).
- Record update on negedge `rst_n` (asynchronous): both records are cleared to bubble immediately.
- Reset values:
  - `forward_ctrl_A`/`B` = 00, `forward_ctrl_ls` = 0, `PC_EN_IF` = 1, `reg_FD_EN` = 1, `reg_DE_flush` = 0.
  - `reg_FD_flush` = `Branch_ID`, since it is combinational.
- All outputs are combinational from the records and the ID inputs. Zero-cycle latency within the cycle.
- Load-use costs exactly one stall cycle. The following cycle sees the load in MEM and selects 11.
- A back-to-back load followed by two dependents gives: stall 1 cycle, then 11, then 00. By then the value is written back, and the regfile uses write-first.
- Reset deasserted mid-stall: the next cycle resumes with empty records and no stall.

## Test plan
- `addi x1,x0,5` in ID, next cycle `add x2,x1,x3` in ID → `forward_ctrl_A`=01, B=00, no stall. One cycle later, `sub x4,x1,x1` gives A=B=10.
- `lw x5,0(x6)` then `add x7,x5,x0` → cycle 1: stall=1, `PC_EN_IF`=0, `reg_DE_flush`=1. Cycle 2: A=11, stall=0.
- `lw x5,0(x6)` then `sw x5,4(x8)` → no stall, B=00. Next cycle `forward_ctrl_ls`=1. With `sw x5,0(x5)` instead, a 1-cycle stall occurs.
- `addi x0,x0,1` then `add x2,x0,x0` → all forwards 00. A `beq` (RegWrite 0, rd field 3) followed by a reader of x3 → 00.
- `lw x5` then `beq x5,x0` with `Branch_ID`=1 → cycle 1: stall=1, `reg_FD_flush`=0. Cycle 2: A=11, `reg_FD_flush`=1.
- Pulse `rst_n` low while EX holds an alu producer of x1 and ID reads x1 → A drops to 00 asynchronously, before the next clock edge.
